filt_src: RTL and testbench

//  Sample/coefficient source for the 15-tap FIR filter: the transmit end of its push interface.

---
 rtl/filt_src_if.sv | 23 ++
 rtl/filt_src.sv | 106 ++++++++++
 tb/tb_filt_src.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filt_src_if.sv
// Sample/coefficient link for the FIR source: producer valid/ready side plus
// the push strobe, sample and flat coefficient bank presented to the filter.
interface filt_src_if #(
  parameter int DW    = 20,
  parameter int NTAPS = 15
);
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       in_x;
  logic                pushin;
  logic [DW-1:0]       x;
  logic [NTAPS*DW-1:0] c_flat;

  modport master (
    input  in_valid, in_x,
    output in_ready, pushin, x, c_flat
  );

  modport slave (
    output in_valid, in_x,
    input  in_ready, pushin, x, c_flat
  );
endinterface

// File: rtl/filt_src.sv
// FIR sample/coefficient source: FIFO-buffered, paced sample pushes and a
// double-buffered coefficient bank that swaps atomically between pushes.
module filt_src #(
  parameter int DW    = 20,
  parameter int NTAPS = 15,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  filt_src_if.master    bus,
  input  logic          run,
  input  logic [7:0]    pace,
  input  logic          cwr_en,
  input  logic [3:0]    cwr_addr,
  input  logic [DW-1:0] cwr_data,
  input  logic          cswap,
  output logic [AW:0]   count,
  output logic          swap_pend
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    gap_q, gap_d;
  logic          pushin_q, pushin_d;
  logic [DW-1:0] x_q, x_d;
  logic          swap_pend_q, swap_pend_d;
  logic [DW-1:0] shadow_q [NTAPS];
  logic [DW-1:0] shadow_d [NTAPS];
  logic [DW-1:0] active_q [NTAPS];
  logic [DW-1:0] active_d [NTAPS];
  logic          accept;
  logic          issue;

  assign bus.in_ready = (count_q < (AW+1)'(DEPTH));

  // NOTE: every always_comb output gets a value on every path (defaults or
  // full if/else), otherwise synthesis infers a latch.
  always_comb begin
    accept   = bus.in_valid && bus.in_ready;
    // Issue looks only at registered occupancy, so a fresh sample waits one edge.
    issue    = run && (count_q != '0) && (gap_q == '0);
    wr_ptr_d = wr_ptr_q + AW'(accept);
    rd_ptr_d = rd_ptr_q + AW'(issue);
    count_d  = count_q + (AW+1)'(accept) - (AW+1)'(issue);
    pushin_d = issue;
    x_d      = issue ? mem_q[rd_ptr_q] : x_q;
    if (issue)            gap_d = pace;
    else if (gap_q != '0) gap_d = gap_q - 8'd1;
    else                  gap_d = gap_q;
    swap_pend_d = swap_pend_q ? 1'b0 : cswap;
    for (int i = 0; i < NTAPS; i++) begin
      shadow_d[i] = (cwr_en && (cwr_addr == 4'(i))) ? cwr_data : shadow_q[i];
      // Copy from shadow_d so a write on the swap edge lands in the new bank.
      active_d[i] = swap_pend_q ? shadow_d[i] : active_q[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      pushin_q    <= 1'b0;
      x_q         <= '0;
      swap_pend_q <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      pushin_q    <= pushin_d;
      x_q         <= x_d;
      swap_pend_q <= swap_pend_d;
      for (int i = 0; i < NTAPS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; pointers and count alone
  // decide which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= bus.in_x;
  end

  for (genvar g = 0; g < NTAPS; g++) begin : g_cflat
    assign bus.c_flat[g*DW +: DW] = active_q[g];
  end

  assign bus.pushin = pushin_q;
  assign bus.x      = x_q;
  assign count      = count_q;
  assign swap_pend  = swap_pend_q;

endmodule

// File: tb/tb_filt_src.sv
// Self-checking bench for filt_src: sample scoreboard plus coefficient model,
// with one task per scenario.
module tb_filt_src;
  localparam int DW    = 20;
  localparam int NTAPS = 15;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [7:0]    pace;
  logic          cwr_en;
  logic [3:0]    cwr_addr;
  logic [DW-1:0] cwr_data;
  logic          cswap;
  logic [AW:0]   count;
  logic          swap_pend;

  filt_src_if #(.DW(DW), .NTAPS(NTAPS)) bus ();

  filt_src #(.DW(DW), .NTAPS(NTAPS), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .run       (run),
    .pace      (pace),
    .cwr_en    (cwr_en),
    .cwr_addr  (cwr_addr),
    .cwr_data  (cwr_data),
    .cswap     (cswap),
    .count     (count),
    .swap_pend (swap_pend)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]       sb_q [$];
  logic [DW-1:0]       m_shadow [NTAPS];
  logic [NTAPS*DW-1:0] m_active;
  logic                m_pend;
  logic [NTAPS*DW-1:0] old_bank, new_bank;

  // Reference model: sample queue and coefficient banks, updated on edges.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q.delete();
      m_pend   = 1'b0;
      m_active = '0;
      for (int i = 0; i < NTAPS; i++) m_shadow[i] = '0;
    end else begin
      if (bus.in_valid && bus.in_ready) sb_q.push_back(bus.in_x);
      if (cwr_en && (int'(cwr_addr) < NTAPS)) m_shadow[cwr_addr] = cwr_data;
      if (m_pend) begin
        for (int i = 0; i < NTAPS; i++) m_active[i*DW +: DW] = m_shadow[i];
        m_pend = 1'b0;
      end else if (cswap) begin
        m_pend = 1'b1;
      end
    end
  end

  // Output monitor: pops the scoreboard on each push, checks occupancy and bank.
  always @(negedge clk) begin
    logic [DW-1:0] exp_x;
    if (!reset) begin
      if (bus.pushin) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL push_unexpected: pushin=1 x=%0d, required no push", $signed(bus.x));
        end else begin
          exp_x = sb_q.pop_front();
          if (bus.x !== exp_x) begin
            errors++;
            $display("FAIL push_x: x=%0d, required %0d", $signed(bus.x), $signed(exp_x));
          end
        end
      end
      checks++;
      if (count !== (AW+1)'(sb_q.size())) begin
        errors++;
        $display("FAIL count: count=%0d, required %0d", count, sb_q.size());
      end
      checks++;
      if (bus.in_ready !== (sb_q.size() < DEPTH)) begin
        errors++;
        $display("FAIL in_ready: in_ready=%b, required %b", bus.in_ready, sb_q.size() < DEPTH);
      end
      checks++;
      if (swap_pend !== m_pend) begin
        errors++;
        $display("FAIL swap_pend: swap_pend=%b, required %b", swap_pend, m_pend);
      end
      checks++;
      if (bus.c_flat !== m_active) begin
        errors++;
        $display("FAIL c_flat: c_flat=%h, required %h", bus.c_flat, m_active);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run = 1'b0; pace = '0; cwr_en = 1'b0; cwr_addr = '0; cwr_data = '0; cswap = 1'b0;
    bus.in_valid = 1'b0; bus.in_x = '0;
    repeat (2) tick();
    checks++;
    if (bus.pushin !== 1'b0 || bus.x !== '0 || count !== '0 || swap_pend !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pushin=%b x=%0d count=%0d swap_pend=%b, required 0 0 0 0",
               bus.pushin, bus.x, count, swap_pend);
    end
    checks++;
    if (bus.c_flat !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_bank: c_flat=%h in_ready=%b, required 0 and 1", bus.c_flat, bus.in_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_x [3];
    exp_x[0] = DW'(5); exp_x[1] = DW'(-7); exp_x[2] = DW'(1);
    run = 1'b1; pace = 8'd0;
    bus.in_valid = 1'b1; bus.in_x = exp_x[0];
    tick();
    checks++;
    if (bus.pushin !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bypass: pushin=%b, required 0", bus.pushin);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) bus.in_x = exp_x[i+1];
      else       bus.in_valid = 1'b0;
      tick();
      checks++;
      if (bus.pushin !== 1'b1 || bus.x !== exp_x[i]) begin
        errors++;
        $display("FAIL b2b_push%0d: pushin=%b x=%0d, required 1 %0d", i, bus.pushin,
                 $signed(bus.x), $signed(exp_x[i]));
      end
    end
    tick();
    checks++;
    if (bus.pushin !== 1'b0 || bus.x !== exp_x[2]) begin
      errors++;
      $display("FAIL b2b_idle_hold: pushin=%b x=%0d, required 0 1", bus.pushin, $signed(bus.x));
    end
  endtask

  task automatic test_pace();
    run = 1'b0; pace = 8'd3;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_x = DW'(100 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (count !== 5'd4) begin
      errors++;
      $display("FAIL pace_preload: count=%0d, required 4", count);
    end
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (bus.pushin !== (i % 4 == 0)) begin
        errors++;
        $display("FAIL pace_period cycle %0d: pushin=%b, required %b", i, bus.pushin, i % 4 == 0);
      end
    end
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL pace_drain: count=%0d, required 0", count);
    end
    pace = 8'd0;
  endtask

  task automatic test_full();
    int  n_acc;
    logic rdy;
    run = 1'b0; n_acc = 0;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && n_acc < DEPTH; cyc++) begin
      bus.in_x = DW'(200 + n_acc);
      rdy = bus.in_ready;
      tick();
      if (rdy) n_acc++;
    end
    bus.in_x = DW'(216);
    checks++;
    if (count !== 5'd16 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_reached: count=%0d in_ready=%b, required 16 0", count, bus.in_ready);
    end
    repeat (3) tick();
    checks++;
    if (count !== 5'd16) begin
      errors++;
      $display("FAIL full_hold: count=%0d, required 16", count);
    end
    run = 1'b1;
    tick();
    checks++;
    if (count !== 5'd15 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_free_slot: count=%0d in_ready=%b, required 15 1", count, bus.in_ready);
    end
    tick();
    checks++;
    if (count !== 5'd15) begin
      errors++;
      $display("FAIL full_accept_issue: count=%0d, required 15", count);
    end
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 50 && count != 0; cyc++) tick();
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL full_drain_timeout: count=%0d, required 0", count);
    end
    run = 1'b0;
  endtask

  task automatic test_coeff_swap();
    cwr_en = 1'b1;
    for (int i = 0; i < NTAPS; i++) begin
      cwr_addr = 4'(i); cwr_data = DW'(i + 1);
      tick();
    end
    cwr_addr = 4'd15; cwr_data = DW'(99);
    tick();
    cwr_en = 1'b0; cswap = 1'b1;
    tick();
    cswap = 1'b0;
    checks++;
    if (swap_pend !== 1'b1 || bus.c_flat !== '0) begin
      errors++;
      $display("FAIL swap_pending: swap_pend=%b c_flat=%h, required 1 and 0", swap_pend, bus.c_flat);
    end
    tick();
    checks++;
    if (swap_pend !== 1'b0) begin
      errors++;
      $display("FAIL swap_clear: swap_pend=%b, required 0", swap_pend);
    end
    for (int i = 0; i < NTAPS; i++) begin
      checks++;
      if (bus.c_flat[i*DW +: DW] !== DW'(i + 1)) begin
        errors++;
        $display("FAIL swap_tap%0d: c=%0d, required %0d", i, bus.c_flat[i*DW +: DW], i + 1);
      end
    end
  endtask

  task automatic test_swap_midstream();
    int n_push;
    for (int i = 0; i < NTAPS; i++) begin
      old_bank[i*DW +: DW] = DW'(i + 1);
      new_bank[i*DW +: DW] = DW'(-1000 * (i + 1));
    end
    run = 1'b0; cwr_en = 1'b1;
    for (int i = 0; i < NTAPS; i++) begin
      cwr_addr = 4'(i); cwr_data = new_bank[i*DW +: DW];
      tick();
    end
    cwr_en = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.in_x = DW'(300 + k);
      tick();
    end
    bus.in_valid = 1'b0;
    run = 1'b1; n_push = 0;
    for (int k = 0; k < 12; k++) begin
      cswap = (k == 3);
      tick();
      if (bus.pushin) begin
        n_push++;
        checks++;
        if (bus.c_flat !== ((k >= 4) ? new_bank : old_bank)) begin
          errors++;
          $display("FAIL midstream_bank cycle %0d: c_flat=%h, required %h", k, bus.c_flat,
                   (k >= 4) ? new_bank : old_bank);
        end
      end
    end
    cswap = 1'b0;
    checks++;
    if (n_push != 8) begin
      errors++;
      $display("FAIL midstream_pushes: pushes=%0d, required 8", n_push);
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.in_x = DW'(400 + k);
      tick();
    end
    bus.in_valid = 1'b0;
    run = 1'b1; cswap = 1'b1;
    tick();
    cswap = 1'b0;
    checks++;
    if (count !== 5'd5 || bus.pushin !== 1'b1 || swap_pend !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: count=%0d pushin=%b swap_pend=%b, required 5 1 1",
               count, bus.pushin, swap_pend);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.pushin !== 1'b0 || count !== '0 || swap_pend !== 1'b0 || bus.c_flat !== '0 ||
        bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: pushin=%b count=%0d swap_pend=%b c_flat=%h in_ready=%b, required 0 0 0 0 1",
               bus.pushin, count, swap_pend, bus.c_flat, bus.in_ready);
    end
    run = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    run = 1'b1;
    bus.in_valid = 1'b1; bus.in_x = DW'(7);
    tick();
    bus.in_x = DW'(8);
    tick();
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && (count != 0 || sb_q.size() != 0); cyc++) tick();
    tick();
    checks++;
    if (count !== '0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_resume: count=%0d pending=%0d, required 0 0", count, sb_q.size());
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_pace();
    test_full();
    test_coeff_swap();
    test_swap_midstream();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_samples: pending=%0d, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
